key_debounce: RTL and testbench

- Conditions a raw, asynchronous mechanical key or switch input into a clean, single-clock-domain level.
- Sits directly upstream of the edge-check stage: key_out drives that stage's ctrl_signal input, so every level change seen there is glitch-free and happens exactly once per physical press or release.
- Structure: a multi-flop synchroniser, a 4-state filter FSM and a consecutive-sample counter.

---
 rtl/key_debounce_if.sv | 23 ++
 rtl/key_debounce.sv | 140 ++++++++++++++
 tb/tb_key_debounce.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/key_debounce_if.sv
// Key debounce port bundle: raw key level in, debounced level and status out.
// No latency of its own; pure wiring between driver and debouncer.
// No backpressure: all signals are levels sampled every sys_clk.
//
// Signals:
//   key_in      raw asynchronous key level (driven by master)
//   key_out     debounced level (driven by slave)
//   key_stable  1 while no filtering is in progress (driven by slave)
//   glitch_cnt  rejected-bounce counter, present only with KEY_DEBOUNCE_GLITCH_CNT_EN
interface key_debounce_if;
    logic       key_in;
    logic       key_out;
    logic       key_stable;
`ifdef KEY_DEBOUNCE_GLITCH_CNT_EN
    logic [7:0] glitch_cnt;

    modport master (output key_in, input key_out, input key_stable, input glitch_cnt);
    modport slave  (input key_in, output key_out, output key_stable, output glitch_cnt);
`else
    modport master (output key_in, input key_out, input key_stable);
    modport slave  (input key_in, output key_out, output key_stable);
`endif
endinterface

// File: rtl/key_debounce.sv
// Debounces a raw mechanical key into a clean sys_clk-domain level.
// Latency: key_out follows a steady key_in change after SYNC_STAGES+DEBOUNCE_CNT-1 edges.
// No backpressure: level in, level out, evaluated every cycle.
//
// Ports:
//   sys_clk  system clock
//   sys_rst  asynchronous active-high reset
//   kb       key_debounce_if.slave (key_in in; key_out, key_stable out)
// Optional: define KEY_DEBOUNCE_GLITCH_CNT_EN to add kb.glitch_cnt, a saturating
// 8-bit count of rejected bounces.
module key_debounce #(
    parameter int       SYNC_STAGES  = 2,
    parameter int       CNT_WIDTH    = 20,
    parameter int       DEBOUNCE_CNT = 1000000,
    parameter logic     IDLE_LEVEL   = 1'b1
) (
    input  logic         sys_clk,
    input  logic         sys_rst,
    key_debounce_if.slave kb
);

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CNT - 1);

    typedef enum logic [1:0] {
        STABLE_IDLE   = 2'd0,
        FILT_ACTIVE   = 2'd1,
        STABLE_ACTIVE = 2'd2,
        FILT_IDLE     = 2'd3
    } state_t;

    // ---------------- synchroniser ----------------
    // key_in goes straight into the first flop; nothing combinational in front.
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   key_sync;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], kb.key_in};
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) sync_q <= {SYNC_STAGES{IDLE_LEVEL}};
        else         sync_q <= sync_d;
    end

    assign key_sync = sync_q[SYNC_STAGES-1];

    // ---------------- filter FSM ----------------
    state_t                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   key_out_q, key_out_d;
    logic                   key_stable_q, key_stable_d;
    logic                   reject;

    // State register (with the counter and registered outputs)
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q      <= STABLE_IDLE;
            cnt_q        <= '0;
            key_out_q    <= IDLE_LEVEL;
            key_stable_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            key_out_q    <= key_out_d;
            key_stable_q <= key_stable_d;
        end
    end

    // Next-state and counter
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        reject  = 1'b0;
        case (state_q)
            STABLE_IDLE, STABLE_ACTIVE: begin
                cnt_d = '0;
                if (key_sync != key_out_q) begin
                    if (DEBOUNCE_CNT == 1) begin
                        // A single sample is enough: accept without filtering.
                        state_d = (state_q == STABLE_IDLE) ? STABLE_ACTIVE : STABLE_IDLE;
                    end else begin
                        // This mismatching sample is the first of the run.
                        state_d = (state_q == STABLE_IDLE) ? FILT_ACTIVE : FILT_IDLE;
                        cnt_d   = CNT_WIDTH'(1);
                    end
                end
            end
            FILT_ACTIVE, FILT_IDLE: begin
                if (key_sync == key_out_q) begin
                    // Bounced back before the run completed.
                    state_d = (state_q == FILT_ACTIVE) ? STABLE_IDLE : STABLE_ACTIVE;
                    cnt_d   = '0;
                    reject  = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = (state_q == FILT_ACTIVE) ? STABLE_ACTIVE : STABLE_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = STABLE_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Registered outputs derived from the next state, so they switch on the
    // same edge as the state itself.
    always_comb begin
        key_out_d    = IDLE_LEVEL;
        key_stable_d = 1'b1;
        if (state_d == STABLE_ACTIVE || state_d == FILT_IDLE) key_out_d = ~IDLE_LEVEL;
        if (state_d == FILT_ACTIVE || state_d == FILT_IDLE)   key_stable_d = 1'b0;
    end

    assign kb.key_out    = key_out_q;
    assign kb.key_stable = key_stable_q;

`ifdef KEY_DEBOUNCE_GLITCH_CNT_EN
    // ---------------- rejected-bounce counter ----------------
    logic [7:0] glitch_cnt_q, glitch_cnt_d;

    always_comb begin
        glitch_cnt_d = glitch_cnt_q;
        if (reject && glitch_cnt_q != 8'hFF) glitch_cnt_d = glitch_cnt_q + 8'd1;
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) glitch_cnt_q <= 8'd0;
        else         glitch_cnt_q <= glitch_cnt_d;
    end

    assign kb.glitch_cnt = glitch_cnt_q;
`else
    logic unused_reject;
    assign unused_reject = reject;
`endif

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce: one instance with DEBOUNCE_CNT=8, one with DEBOUNCE_CNT=1.
// key_out transitions are matched against a queue of expected (cycle, level) events.
// Stimulus is applied on the falling edge; outputs are sampled on the falling edge.
module tb_key_debounce;

    typedef struct {
        int   cyc;
        logic lvl;
    } ev_t;

    logic sys_clk;
    logic sys_rst;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    ev_t  qa[$];
    ev_t  qb[$];
    logic last_a = 1'b1;
    logic last_b = 1'b1;

    key_debounce_if if_a ();
    key_debounce_if if_b ();

    key_debounce #(.SYNC_STAGES(2), .CNT_WIDTH(4), .DEBOUNCE_CNT(8), .IDLE_LEVEL(1'b1)) u_dut_a (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .kb      (if_a)
    );

    key_debounce #(.SYNC_STAGES(2), .CNT_WIDTH(4), .DEBOUNCE_CNT(1), .IDLE_LEVEL(1'b1)) u_dut_b (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .kb      (if_b)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Edge numbering: cyc counts rising edges seen so far.
    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Monitors: every change of key_out must match the next expected event.
    always @(negedge sys_clk) begin
        ev_t e;
        if (if_a.key_out !== last_a) begin
            if (qa.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL a_unexpected_edge: key_out became %0d at cycle %0d, none expected",
                         if_a.key_out, cyc);
            end else begin
                e = qa.pop_front();
                check("a_edge_cycle", cyc, e.cyc);
                check("a_edge_level", if_a.key_out, e.lvl);
            end
            last_a = if_a.key_out;
        end
    end

    always @(negedge sys_clk) begin
        ev_t e;
        if (if_b.key_out !== last_b) begin
            if (qb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL b_unexpected_edge: key_out became %0d at cycle %0d, none expected",
                         if_b.key_out, cyc);
            end else begin
                e = qb.pop_front();
                check("b_edge_cycle", cyc, e.cyc);
                check("b_edge_level", if_b.key_out, e.lvl);
            end
            last_b = if_b.key_out;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    // Drive A's key and expect key_out to reach lvl 9 edges after the capture edge.
    task automatic press_a(input logic lvl);
        @(negedge sys_clk);
        if_a.key_in = lvl;
        qa.push_back('{cyc + 10, lvl});
        repeat (14) @(negedge sys_clk);
    endtask

    initial begin
        int d;
        int c;
        int r;
        if_a.key_in = 1'b1;
        if_b.key_in = 1'b1;
        sys_rst     = 1'b0;
        #1 sys_rst = 1'b1;
        #1;
        check("rst_a_key_out", if_a.key_out, 1);
        check("rst_a_key_stable", if_a.key_stable, 1);
        check("rst_b_key_out", if_b.key_out, 1);
`ifdef KEY_DEBOUNCE_GLITCH_CNT_EN
        check("rst_glitch_cnt", if_a.glitch_cnt, 0);
`endif
        @(negedge sys_clk);
        @(negedge sys_clk);
        sys_rst = 1'b0;
        repeat (4) @(negedge sys_clk);

        // DEBOUNCE_CNT=1: accepted at edge 2, never leaves the stable states.
        @(negedge sys_clk);
        if_b.key_in = 1'b0;
        d = cyc;
        qb.push_back('{d + 3, 1'b0});
        for (int k = 0; k < 6; k++) begin
            @(negedge sys_clk);
            check("b_key_stable", if_b.key_stable, 1);
        end
        @(negedge sys_clk);
        if_b.key_in = 1'b1;
        d = cyc;
        qb.push_back('{d + 3, 1'b1});
        repeat (6) @(negedge sys_clk);

        // Clean press: key_stable low after edges 2..8, key_out falls at edge 9.
        @(negedge sys_clk);
        if_a.key_in = 1'b0;
        d = cyc;
        qa.push_back('{d + 10, 1'b0});
        for (int k = 0; k < 12; k++) begin
            @(negedge sys_clk);
            check("a_press_key_stable", if_a.key_stable, (k >= 2 && k <= 8) ? 0 : 1);
        end
        repeat (4) @(negedge sys_clk);
        press_a(1'b1);

        // Bounce: 3-cycle pulses for 40 cycles (7 low pulses), then settle low.
        for (int i = 0; i < 40; i++) begin
            @(negedge sys_clk);
            if_a.key_in = ((i / 3) % 2 == 0) ? 1'b0 : 1'b1;
        end
        press_a(1'b0);
`ifdef KEY_DEBOUNCE_GLITCH_CNT_EN
        check("bounce_glitch_cnt", if_a.glitch_cnt, 7);
`endif
        press_a(1'b1);

        // Exactly 7 low samples: rejected.
        @(negedge sys_clk);
        if_a.key_in = 1'b0;
        repeat (7) @(negedge sys_clk);
        if_a.key_in = 1'b1;
        repeat (20) @(negedge sys_clk);
        check("boundary7_key_out", if_a.key_out, 1);
`ifdef KEY_DEBOUNCE_GLITCH_CNT_EN
        check("boundary7_glitch_cnt", if_a.glitch_cnt, 8);
`endif

        // Exactly 8 low samples: accepted at the last one; release rises 9 edges later.
        @(negedge sys_clk);
        if_a.key_in = 1'b0;
        d = cyc;
        qa.push_back('{d + 10, 1'b0});
        qa.push_back('{d + 18, 1'b1});
        repeat (8) @(negedge sys_clk);
        if_a.key_in = 1'b1;
        repeat (20) @(negedge sys_clk);

        // Asynchronous reset while key_out is low and key_in held low.
        press_a(1'b0);
        @(negedge sys_clk);
        c = cyc;
        qa.push_back('{c + 1, 1'b1});
        #2 sys_rst = 1'b1;
        #1;
        check("async_rst_key_out", if_a.key_out, 1);
        check("async_rst_key_stable", if_a.key_stable, 1);
`ifdef KEY_DEBOUNCE_GLITCH_CNT_EN
        check("async_rst_glitch_cnt", if_a.glitch_cnt, 0);
`endif
        @(negedge sys_clk);
        @(negedge sys_clk);
        sys_rst = 1'b0;
        r = cyc;
        qa.push_back('{r + 10, 1'b0});
        for (int k = 0; k < 8; k++) begin
            @(negedge sys_clk);
            check("post_rst_key_out_hold", if_a.key_out, 1);
        end
        repeat (6) @(negedge sys_clk);
        press_a(1'b1);

        // Reset in the middle of a filter: nothing survives, next press takes full latency.
        @(negedge sys_clk);
        if_a.key_in = 1'b0;
        repeat (5) @(negedge sys_clk);
        #2 sys_rst = 1'b1;
        if_a.key_in = 1'b1;
        @(negedge sys_clk);
        sys_rst = 1'b0;
        repeat (20) @(negedge sys_clk);
        check("midfilt_rst_key_out", if_a.key_out, 1);
        check("midfilt_rst_key_stable", if_a.key_stable, 1);
        press_a(1'b0);
        press_a(1'b1);

`ifdef KEY_DEBOUNCE_GLITCH_CNT_EN
        // 300 rejected 2-sample glitches: counter saturates.
        for (int i = 0; i < 300; i++) begin
            @(negedge sys_clk);
            if_a.key_in = 1'b0;
            @(negedge sys_clk);
            @(negedge sys_clk);
            if_a.key_in = 1'b1;
            @(negedge sys_clk);
        end
        repeat (10) @(negedge sys_clk);
        check("glitch_cnt_saturate", if_a.glitch_cnt, 255);
`endif

        repeat (20) @(negedge sys_clk);
        check("a_events_outstanding", qa.size(), 0);
        check("b_events_outstanding", qb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
